prvp_spi_slave_cmd_ctrl: RTL and testbench
==========================================

Name: prvp_spi_slave_cmd_ctrl

Overview:
- SPI-slave protocol controller in the AXI clock domain, between the SPI bit-shifter frontend and the SPI-to-AXI bridge plug.
- Decodes command, address, dummy and data phases from frontend units; drives bridge rxtx_addr/rxtx_addr_valid/start_tx/cs.
- Buffers write words in a small FIFO; holds the wrap_length and dummy-cycle configuration registers.

Parameters:
AXI_ADDR_WIDTH, 32, address width forwarded to the bridge
WFIFO_DEPTH, 4, write-data FIFO entries (power of 2, >=2)
DUMMY_RST, 32, reset value of dummy-cycle register (bits)

Ports:
axi_aclk  in  1  clock
axi_areset  in  1  asynchronous active-high reset
fe_cs_n  in  1  synchronized SPI chip select, active low
fe_data  in  32  received unit, right-aligned
fe_valid  in  1  one-cycle pulse: unit of fe_rx_len bits complete
fe_rx_len  out  6  length in bits of the next unit to receive (0 = 64)
fe_tx_en  out  1  frontend shifts out tx words instead of receiving
fe_tx_data  out  32  word to shift out
fe_tx_valid  out  1  fe_tx_data valid
fe_tx_ready  in  1  frontend consumed fe_tx_data
rxtx_addr  out  AXI_ADDR_WIDTH  start address to bridge
rxtx_addr_valid  out  1  one-cycle address load pulse
start_tx  out  1  one-cycle read start pulse
cs  out  1  registered copy of fe_cs_n
tx_data  in  32  read word from bridge
tx_valid  in  1  bridge read word valid
tx_ready  out  1  read word accepted
rx_data  out  32  write word to bridge (FIFO head)
rx_valid  out  1  FIFO not empty
rx_ready  in  1  bridge pops FIFO head
wrap_length  out  16  burst wrap length to bridge
overflow  out  1  sticky: write word dropped, FIFO full

Behaviour:
- Reset: state IDLE, all pulses 0, fe_rx_len=8, fe_tx_en=0, rxtx_addr=0, cs=1, FIFO empty, wrap_length=16'h0001, dummy=DUMMY_RST, overflow=0.
- States: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, REGWR, IGNORE.
- IDLE: fe_cs_n=0 -> CMD, fe_rx_len=8.
- CMD on fe_valid, fe_data[7:0]: 0x02 write-mem, 0x0B read-mem -> ADDR (len 32); 0x11 write wrap_length, 0x12 write dummy -> REGWR (len 16); other -> IGNORE.
- ADDR on fe_valid: rxtx_addr<=fe_data, rxtx_addr_valid pulse next cycle. Write -> WDATA (len 32). Read -> start_tx pulse same cycle as rxtx_addr_valid; dummy!=0 -> DUMMY (len=dummy[5:0]), else -> RDATA.
- DUMMY: fe_valid -> RDATA; data discarded.
- RDATA: fe_tx_en=1; fe_tx_data=tx_data, fe_tx_valid=tx_valid, tx_ready=fe_tx_ready (combinational passthrough).
- WDATA: each fe_valid pushes fe_data; FIFO full -> word dropped, overflow<=1 (sticky until reset).
- REGWR: fe_valid writes fe_data[15:0] to wrap_length (0x11, value 0 forced to 1) or fe_data[5:0] to dummy (0x12) -> IGNORE.
- IGNORE: discard units until fe_cs_n=1.
- fe_cs_n=1 in any state -> IDLE next cycle, fe_rx_len=8, fe_tx_en=0; FIFO not flushed, drains to bridge. Partial units discarded.
- fe_valid with fe_cs_n=1 same cycle: unit ignored.
- cs registered one cycle.
- FIFO: rx_data=head, rx_valid=!empty; simultaneous push and pop when full: pop first, push accepted, no overflow.

Optional Feature:
- PRVP_SPI_CMD_REGRD_EN defined: command 0x07 -> RDATA-like REGRD state; fe_tx_data={overflow,9'b0,dummy[5:0],wrap_length}, fe_tx_valid=1, tx_ready=0; word repeats until fe_cs_n=1.
- Undefined: 0x07 -> IGNORE; mux logic absent.

Decomposition:
- Package prvp_spi_cmd_pkg: state enum, opcode constants (0x02,0x0B,0x11,0x12,0x07), unit-length constants 8/16/32.
- Sub-module prvp_spi_cmd_wfifo: synchronous FIFO, WFIFO_DEPTH, push/pop/full/empty.

Test Plan:
- Write: cs_n low, 0x02, addr 0x1C000100, words 0xDEADBEEF, 0x12345678 -> rxtx_addr_valid one pulse with 0x1C000100; rx_data sequence matches with rx_ready=1; overflow=0.
- Read, dummy=32: 0x0B, addr 0x1C000200 -> start_tx one pulse; DUMMY len 32; RDATA passes tx_data 0xCAFEF00D to fe_tx_data, tx_ready follows fe_tx_ready.
- Config: 0x11 with 0x0008 then 0x12 with 0x00 -> wrap_length=8; next read skips DUMMY straight to RDATA.
- Overflow: rx_ready=0, push 5 words with depth 4 -> overflow=1, first 4 words kept in order.
- Abort: fe_cs_n high mid-ADDR -> IDLE, no rxtx_addr_valid/start_tx; unknown opcode 0x55 -> IGNORE, no outputs.
- Reset mid-WDATA with 2 words queued -> rx_valid=0, state IDLE, wrap_length=1.

Source files
------------

// File: rtl/prvp_spi_cmd_pkg.sv
// Shared types and constants for the SPI-slave command controller.
// No logic: FSM state encoding, opcode values and receive-unit lengths.
// Imported by the controller top and its write-data FIFO.
package prvp_spi_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WDATA,
        ST_RDATA,
        ST_REGWR,
        ST_IGNORE,
        ST_REGRD
    } state_t;

    localparam logic [7:0] OP_WRITE_MEM = 8'h02;
    localparam logic [7:0] OP_READ_MEM  = 8'h0B;
    localparam logic [7:0] OP_WR_WRAP   = 8'h11;
    localparam logic [7:0] OP_WR_DUMMY  = 8'h12;
    localparam logic [7:0] OP_RD_REGS   = 8'h07;

    localparam logic [5:0] LEN_8  = 6'd8;
    localparam logic [5:0] LEN_16 = 6'd16;
    localparam logic [5:0] LEN_32 = 6'd32;

    // A zero wrap length has no meaning for the bridge; treat it as single beat.
    function automatic logic [15:0] wrap_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/prvp_spi_cmd_wfifo.sv
// Write-data FIFO between the SPI command decoder and the AXI bridge.
// Latency: a pushed word is visible at o_head the cycle after the push.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module prvp_spi_cmd_wfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_pop_en;
    logic             w_push_en;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_en  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot being written, so full does not block it.
    assign w_push_en = i_push && (!o_full || w_pop_en);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/prvp_spi_slave_cmd_ctrl.sv
// SPI-slave command controller: decodes cmd/addr/dummy/data units, drives bridge, holds config regs.
// Latency: rxtx_addr/rxtx_addr_valid/start_tx one cycle after the address unit; read data is combinational.
// Backpressure: reads pass ready/valid through; writes buffer in a FIFO, words dropped when full set overflow.
// Optional: define PRVP_SPI_CMD_REGRD_EN to add opcode 0x07 (read back overflow/dummy/wrap_length).
module prvp_spi_slave_cmd_ctrl
    import prvp_spi_cmd_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int WFIFO_DEPTH    = 4,
    parameter int DUMMY_RST      = 32
) (
    input  logic                      axi_aclk,
    input  logic                      axi_areset,
    input  logic                      fe_cs_n,
    input  logic [31:0]               fe_data,
    input  logic                      fe_valid,
    output logic [5:0]                fe_rx_len,
    output logic                      fe_tx_en,
    output logic [31:0]               fe_tx_data,
    output logic                      fe_tx_valid,
    input  logic                      fe_tx_ready,
    output logic [AXI_ADDR_WIDTH-1:0] rxtx_addr,
    output logic                      rxtx_addr_valid,
    output logic                      start_tx,
    output logic                      cs,
    input  logic [31:0]               tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [31:0]               rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [15:0]               wrap_length,
    output logic                      overflow
);
    localparam logic [5:0] DUMMY_RST_L = 6'(DUMMY_RST);

    state_t                    r_state;
    logic [7:0]                r_op;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic                      r_addr_vld;
    logic                      r_start;
    logic [5:0]                r_rx_len;
    logic                      r_tx_en;
    logic                      r_cs;
    logic [15:0]               r_wrap;
    logic [5:0]                r_dummy;
    logic                      r_ovf;

    logic                      w_push;
    logic                      w_full;
    logic                      w_empty;
    logic [31:0]               w_tx_dat;
    logic                      w_tx_vld;
    logic                      w_tx_rdy;

    // A unit arriving while chip select is released belongs to no transaction.
    assign w_push = (r_state == ST_WDATA) && fe_valid && !fe_cs_n;

    prvp_spi_cmd_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .WIDTH (32)
    ) u_wfifo (
        .clk        (axi_aclk),
        .rst        (axi_areset),
        .i_push     (w_push),
        .i_push_dat (fe_data),
        .i_pop      (rx_ready),
        .o_head     (rx_data),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Protocol FSM with registered bridge pulses, unit lengths and config registers.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state    <= ST_IDLE;
            r_op       <= 8'd0;
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
            r_start    <= 1'b0;
            r_rx_len   <= LEN_8;
            r_tx_en    <= 1'b0;
            r_wrap     <= 16'h0001;
            r_dummy    <= DUMMY_RST_L;
            r_ovf      <= 1'b0;
        end else begin
            r_addr_vld <= 1'b0;
            r_start    <= 1'b0;
            // Full with no pop this cycle means the word is lost.
            if (w_push && w_full && !rx_ready) r_ovf <= 1'b1;
            if (fe_cs_n) begin
                r_state  <= ST_IDLE;
                r_rx_len <= LEN_8;
                r_tx_en  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state  <= ST_CMD;
                        r_rx_len <= LEN_8;
                    end
                    ST_CMD: if (fe_valid) begin
                        r_op <= fe_data[7:0];
                        case (fe_data[7:0])
                            OP_WRITE_MEM, OP_READ_MEM: begin
                                r_state  <= ST_ADDR;
                                r_rx_len <= LEN_32;
                            end
                            OP_WR_WRAP, OP_WR_DUMMY: begin
                                r_state  <= ST_REGWR;
                                r_rx_len <= LEN_16;
                            end
`ifdef PRVP_SPI_CMD_REGRD_EN
                            OP_RD_REGS: begin
                                r_state <= ST_REGRD;
                                r_tx_en <= 1'b1;
                            end
`endif
                            default: r_state <= ST_IGNORE;
                        endcase
                    end
                    ST_ADDR: if (fe_valid) begin
                        r_addr     <= AXI_ADDR_WIDTH'(fe_data);
                        r_addr_vld <= 1'b1;
                        if (r_op == OP_WRITE_MEM) begin
                            r_state  <= ST_WDATA;
                            r_rx_len <= LEN_32;
                        end else begin
                            r_start <= 1'b1;
                            if (r_dummy != 6'd0) begin
                                r_state  <= ST_DUMMY;
                                r_rx_len <= r_dummy;
                            end else begin
                                r_state  <= ST_RDATA;
                                r_rx_len <= LEN_32;
                                r_tx_en  <= 1'b1;
                            end
                        end
                    end
                    ST_DUMMY: if (fe_valid) begin
                        r_state  <= ST_RDATA;
                        r_rx_len <= LEN_32;
                        r_tx_en  <= 1'b1;
                    end
                    ST_REGWR: if (fe_valid) begin
                        if (r_op == OP_WR_WRAP) r_wrap <= wrap_sanitize(fe_data[15:0]);
                        else                    r_dummy <= fe_data[5:0];
                        r_state <= ST_IGNORE;
                    end
                    // WDATA pushes via the FIFO; RDATA, REGRD and IGNORE hold until chip select rises.
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // Chip select echo to the bridge, one cycle behind the frontend.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) r_cs <= 1'b1;
        else            r_cs <= fe_cs_n;
    end

    // Transmit path: bridge read data straight through while in the read-data phase.
    always_comb begin
        w_tx_dat = 32'd0;
        w_tx_vld = 1'b0;
        w_tx_rdy = 1'b0;
        if (r_state == ST_RDATA) begin
            w_tx_dat = tx_data;
            w_tx_vld = tx_valid;
            w_tx_rdy = fe_tx_ready;
        end
`ifdef PRVP_SPI_CMD_REGRD_EN
        else if (r_state == ST_REGRD) begin
            w_tx_dat = {r_ovf, 9'b0, r_dummy, r_wrap};
            w_tx_vld = 1'b1;
        end
`endif
    end

    assign fe_rx_len       = r_rx_len;
    assign fe_tx_en        = r_tx_en;
    assign fe_tx_data      = w_tx_dat;
    assign fe_tx_valid     = w_tx_vld;
    assign tx_ready        = w_tx_rdy;
    assign rxtx_addr       = r_addr;
    assign rxtx_addr_valid = r_addr_vld;
    assign start_tx        = r_start;
    assign cs              = r_cs;
    assign rx_valid        = !w_empty;
    assign wrap_length     = r_wrap;
    assign overflow        = r_ovf;

endmodule

// File: tb/tb_prvp_spi_slave_cmd_ctrl.sv
// Self-checking bench for prvp_spi_slave_cmd_ctrl against a transaction-level model.
// Inputs change 1 ns after the rising edge; monitors sample on the falling edge.
// Model tracks config registers, sticky overflow and the expected write-word stream.
`timescale 1ns/1ps
module tb_prvp_spi_slave_cmd_ctrl;

    logic        axi_aclk = 1'b0;
    logic        axi_areset;
    logic        fe_cs_n;
    logic [31:0] fe_data;
    logic        fe_valid;
    logic [5:0]  fe_rx_len;
    logic        fe_tx_en;
    logic [31:0] fe_tx_data;
    logic        fe_tx_valid;
    logic        fe_tx_ready;
    logic [31:0] rxtx_addr;
    logic        rxtx_addr_valid;
    logic        start_tx;
    logic        cs;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] wrap_length;
    logic        overflow;

    always #5 axi_aclk = ~axi_aclk;

    prvp_spi_slave_cmd_ctrl #(
        .AXI_ADDR_WIDTH (32),
        .WFIFO_DEPTH    (4),
        .DUMMY_RST      (32)
    ) dut (
        .axi_aclk        (axi_aclk),
        .axi_areset      (axi_areset),
        .fe_cs_n         (fe_cs_n),
        .fe_data         (fe_data),
        .fe_valid        (fe_valid),
        .fe_rx_len       (fe_rx_len),
        .fe_tx_en        (fe_tx_en),
        .fe_tx_data      (fe_tx_data),
        .fe_tx_valid     (fe_tx_valid),
        .fe_tx_ready     (fe_tx_ready),
        .rxtx_addr       (rxtx_addr),
        .rxtx_addr_valid (rxtx_addr_valid),
        .start_tx        (start_tx),
        .cs              (cs),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .wrap_length     (wrap_length),
        .overflow        (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] m_wrap;
    logic [5:0]  m_dummy;
    logic        m_ovf;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // Observed bridge-side events
    int          n_av   = 0;
    int          n_st   = 0;
    int          n_both = 0;
    logic [31:0] last_addr = 32'd0;

    always @(negedge axi_aclk) begin
        if (!axi_areset) begin
            if (rxtx_addr_valid) begin
                n_av++;
                last_addr = rxtx_addr;
            end
            if (start_tx) n_st++;
            if (rxtx_addr_valid && start_tx) n_both++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge axi_aclk);
            #1;
        end
    endtask

    task automatic cs_begin();
        fe_cs_n = 1'b0;
        tick(1);
    endtask

    task automatic cs_end();
        fe_cs_n = 1'b1;
        tick(2);
    endtask

    // One frontend unit; reports the unit length the DUT requested for it.
    task automatic send_unit(input logic [31:0] d, output logic [5:0] len_seen);
        tick($urandom_range(0, 1));
        len_seen = fe_rx_len;
        fe_data  = d;
        fe_valid = 1'b1;
        tick(1);
        fe_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_wrap  = 16'h0001;
        m_dummy = 6'd32;
        m_ovf   = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        n_checks++; if (fe_rx_len !== 6'd8) begin n_fail++; $display("FAIL reset_rx_len: got %0d want 8", fe_rx_len); end
        n_checks++; if (fe_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %b want 0", fe_tx_en); end
        n_checks++; if (rxtx_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rxtx_addr); end
        n_checks++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (wrap_length !== m_wrap) begin n_fail++; $display("FAIL reset_wrap: got %h want %h", wrap_length, m_wrap); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if ({rxtx_addr_valid, start_tx} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {rxtx_addr_valid, start_tx}); end
    endtask

    task automatic test_write(input logic [31:0] addr, input int nw, input logic [31:0] w0, input logic [31:0] w1);
        logic [5:0]  len;
        logic [31:0] w;
        int av0 = n_av;
        int st0 = n_st;
        rx_ready = 1'b1;
        cs_begin();
        send_unit({24'd0, 8'h02}, len);
        n_checks++; if (len !== 6'd8) begin n_fail++; $display("FAIL wr_cmd_len: got %0d want 8", len); end
        send_unit(addr, len);
        n_checks++; if (len !== 6'd32) begin n_fail++; $display("FAIL wr_addr_len: got %0d want 32", len); end
        for (int i = 0; i < nw; i++) begin
            w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom();
            send_unit(w, len);
            exp_q.push_back(w);
            n_checks++; if (len !== 6'd32) begin n_fail++; $display("FAIL wr_data_len: word %0d got %0d want 32", i, len); end
        end
        n_checks++; if (cs !== 1'b0) begin n_fail++; $display("FAIL wr_cs_low: got %b want 0", cs); end
        cs_end();
        n_checks++; if (n_av !== av0 + 1) begin n_fail++; $display("FAIL wr_addr_pulses: got %0d want %0d", n_av - av0, 1); end
        n_checks++; if (last_addr !== addr) begin n_fail++; $display("FAIL wr_addr_value: got %h want %h", last_addr, addr); end
        n_checks++; if (n_st !== st0) begin n_fail++; $display("FAIL wr_no_start: got %0d start pulses want 0", n_st - st0); end
        for (int c = 0; c < 40 && got_q.size() < exp_q.size(); c++) tick(1);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL wr_drain_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        exp_q.delete();
        got_q.delete();
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL wr_overflow: got %b want %b", overflow, m_ovf); end
    endtask

    task automatic test_read(input logic [31:0] addr, input logic [31:0] first_word);
        logic [5:0] len;
        int av0 = n_av;
        int st0 = n_st;
        int bo0 = n_both;
        cs_begin();
        send_unit({24'd0, 8'h0B}, len);
        n_checks++; if (len !== 6'd8) begin n_fail++; $display("FAIL rd_cmd_len: got %0d want 8", len); end
        send_unit(addr, len);
        n_checks++; if (len !== 6'd32) begin n_fail++; $display("FAIL rd_addr_len: got %0d want 32", len); end
        if (m_dummy != 6'd0) begin
            n_checks++; if (fe_tx_en !== 1'b0) begin n_fail++; $display("FAIL rd_dummy_tx_en: got %b want 0", fe_tx_en); end
            send_unit($urandom(), len);
            n_checks++; if (len !== m_dummy) begin n_fail++; $display("FAIL rd_dummy_len: got %0d want %0d", len, m_dummy); end
        end
        n_checks++; if (fe_tx_en !== 1'b1) begin n_fail++; $display("FAIL rd_tx_en: got %b want 1", fe_tx_en); end
        for (int i = 0; i < 4; i++) begin
            tx_data     = (i == 0) ? first_word : $urandom();
            tx_valid    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            fe_tx_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (fe_tx_data !== tx_data) begin n_fail++; $display("FAIL rd_pass_data: got %h want %h", fe_tx_data, tx_data); end
            n_checks++; if (fe_tx_valid !== tx_valid) begin n_fail++; $display("FAIL rd_pass_valid: got %b want %b", fe_tx_valid, tx_valid); end
            n_checks++; if (tx_ready !== fe_tx_ready) begin n_fail++; $display("FAIL rd_pass_ready: got %b want %b", tx_ready, fe_tx_ready); end
            tick(1);
        end
        n_checks++; if (n_av !== av0 + 1) begin n_fail++; $display("FAIL rd_addr_pulses: got %0d want 1", n_av - av0); end
        n_checks++; if (n_st !== st0 + 1) begin n_fail++; $display("FAIL rd_start_pulses: got %0d want 1", n_st - st0); end
        n_checks++; if (n_both !== bo0 + 1) begin n_fail++; $display("FAIL rd_pulse_align: got %0d coincident want 1", n_both - bo0); end
        n_checks++; if (last_addr !== addr) begin n_fail++; $display("FAIL rd_addr_value: got %h want %h", last_addr, addr); end
        cs_end();
        tx_valid    = 1'b1;
        fe_tx_ready = 1'b1;
        #1;
        n_checks++; if ({fe_tx_en, fe_tx_valid, tx_ready} !== 3'b000) begin n_fail++; $display("FAIL rd_idle_tx: got %b want 000", {fe_tx_en, fe_tx_valid, tx_ready}); end
        tx_valid    = 1'b0;
        fe_tx_ready = 1'b0;
    endtask

    task automatic test_reg_write(input logic [7:0] op, input logic [15:0] val);
        logic [5:0] len;
        cs_begin();
        send_unit({24'd0, op}, len);
        n_checks++; if (len !== 6'd8) begin n_fail++; $display("FAIL reg_cmd_len: got %0d want 8", len); end
        send_unit({16'd0, val}, len);
        n_checks++; if (len !== 6'd16) begin n_fail++; $display("FAIL reg_val_len: got %0d want 16", len); end
        // Further units in the same select must not touch the registers.
        send_unit($urandom(), len);
        cs_end();
        if (op == 8'h11) m_wrap = (val == 16'd0) ? 16'd1 : val;
        else             m_dummy = val[5:0];
        n_checks++; if (wrap_length !== m_wrap) begin n_fail++; $display("FAIL reg_wrap: got %h want %h", wrap_length, m_wrap); end
    endtask

    task automatic test_full_pop_push();
        logic [5:0]  len;
        logic [31:0] w;
        rx_ready = 1'b0;
        cs_begin();
        send_unit({24'd0, 8'h02}, len);
        send_unit($urandom(), len);
        for (int i = 0; i < 4; i++) begin
            w = $urandom();
            send_unit(w, len);
            exp_q.push_back(w);
        end
        w = $urandom();
        exp_q.push_back(w);
        fe_data  = w;
        fe_valid = 1'b1;
        rx_ready = 1'b1;
        tick(1);
        fe_valid = 1'b0;
        rx_ready = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
        cs_end();
        rx_ready = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < exp_q.size(); c++) tick(1);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL fpp_drain_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fpp_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_overflow();
        logic [5:0]  len;
        logic [31:0] w;
        rx_ready = 1'b0;
        cs_begin();
        send_unit({24'd0, 8'h02}, len);
        send_unit(32'h1C000300, len);
        for (int i = 0; i < 5; i++) begin
            w = $urandom();
            send_unit(w, len);
            if (i < 4) exp_q.push_back(w);
            if (i == 3) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
            end
        end
        m_ovf = 1'b1;
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_set: got %b want %b", overflow, m_ovf); end
        cs_end();
        rx_ready = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < exp_q.size(); c++) tick(1);
        tick(2);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_drain_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        exp_q.delete();
        got_q.delete();
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_sticky: got %b want %b", overflow, m_ovf); end
    endtask

    task automatic test_abort();
        logic [5:0] len;
        int av0 = n_av;
        int st0 = n_st;
        // Chip select rises during the address phase, with a unit in the same cycle.
        cs_begin();
        send_unit({24'd0, 8'h0B}, len);
        fe_cs_n  = 1'b1;
        fe_data  = 32'h1C000400;
        fe_valid = 1'b1;
        tick(1);
        fe_valid = 1'b0;
        tick(1);
        n_checks++; if (fe_rx_len !== 6'd8) begin n_fail++; $display("FAIL abort_rx_len: got %0d want 8", fe_rx_len); end
        n_checks++; if (n_av !== av0 || n_st !== st0) begin n_fail++; $display("FAIL abort_pulses: got %0d/%0d want 0/0", n_av - av0, n_st - st0); end
        // Unknown opcode: everything until deselect is discarded.
        cs_begin();
        send_unit({24'd0, 8'h55}, len);
        send_unit({24'd0, 8'h02}, len);
        send_unit(32'h1C000500, len);
        send_unit($urandom(), len);
        n_checks++; if (fe_tx_en !== 1'b0) begin n_fail++; $display("FAIL ign_tx_en: got %b want 0", fe_tx_en); end
        cs_end();
        n_checks++; if (n_av !== av0 || n_st !== st0) begin n_fail++; $display("FAIL ign_pulses: got %0d/%0d want 0/0", n_av - av0, n_st - st0); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ign_rx_valid: got %b want 0", rx_valid); end
        // Register read-back opcode.
        tx_valid    = 1'b1;
        fe_tx_ready = 1'b1;
        cs_begin();
        send_unit({24'd0, 8'h07}, len);
        tick(1);
`ifdef PRVP_SPI_CMD_REGRD_EN
        n_checks++; if (fe_tx_en !== 1'b1) begin n_fail++; $display("FAIL regrd_tx_en: got %b want 1", fe_tx_en); end
        n_checks++; if (fe_tx_data !== {m_ovf, 9'b0, m_dummy, m_wrap}) begin n_fail++; $display("FAIL regrd_data: got %h want %h", fe_tx_data, {m_ovf, 9'b0, m_dummy, m_wrap}); end
        n_checks++; if ({fe_tx_valid, tx_ready} !== 2'b10) begin n_fail++; $display("FAIL regrd_hs: got %b want 10", {fe_tx_valid, tx_ready}); end
`else
        n_checks++; if ({fe_tx_en, fe_tx_valid, tx_ready} !== 3'b000) begin n_fail++; $display("FAIL op07_ignored: got %b want 000", {fe_tx_en, fe_tx_valid, tx_ready}); end
`endif
        cs_end();
        tx_valid    = 1'b0;
        fe_tx_ready = 1'b0;
    endtask

    task automatic test_random(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 3);
            case (k)
                0: test_write($urandom(), $urandom_range(1, 4), $urandom(), $urandom());
                1: test_read($urandom(), $urandom());
                2: test_reg_write(8'h11, ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom()));
                default: test_reg_write(8'h12, ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom()));
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] len;
        test_reg_write(8'h11, 16'h0005);
        rx_ready = 1'b0;
        cs_begin();
        send_unit({24'd0, 8'h02}, len);
        send_unit(32'h1C000600, len);
        send_unit($urandom(), len);
        send_unit($urandom(), len);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_queued: got %b want 1", rx_valid); end
        axi_areset = 1'b1;
        #1;
        model_reset();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b want 0", rx_valid); end
        n_checks++; if (wrap_length !== m_wrap) begin n_fail++; $display("FAIL rstmid_wrap: got %h want %h", wrap_length, m_wrap); end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rstmid_overflow: got %b want %b", overflow, m_ovf); end
        n_checks++; if ({fe_rx_len, fe_tx_en, cs} !== {6'd8, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rstmid_idle: got len=%0d tx_en=%b cs=%b want 8/0/1", fe_rx_len, fe_tx_en, cs); end
        tick(2);
        axi_areset = 1'b0;
        rx_ready   = 1'b1;
        cs_end();
        got_q.delete();
    endtask

    initial begin
        axi_areset  = 1'b1;
        fe_cs_n     = 1'b1;
        fe_data     = 32'd0;
        fe_valid    = 1'b0;
        fe_tx_ready = 1'b0;
        tx_data     = 32'd0;
        tx_valid    = 1'b0;
        rx_ready    = 1'b0;
        model_reset();
        tick(3);
        axi_areset = 1'b0;
        tick(1);

        test_reset();
        test_write(32'h1C000100, 2, 32'hDEADBEEF, 32'h12345678);
        test_read(32'h1C000200, 32'hCAFEF00D);
        test_reg_write(8'h11, 16'h0008);
        test_reg_write(8'h12, 16'h0000);
        test_read(32'h1C000210, 32'h0BADF00D);
        test_reg_write(8'h11, 16'h0000);
        test_reg_write(8'h12, 16'h0007);
        test_full_pop_push();
        test_overflow();
        test_abort();
        test_random(12);
        test_reset_mid();
        test_read(32'h1C000700, 32'h5A5AA5A5);
        test_write(32'h1C000800, 3, 32'h00000001, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
